// File: rtl/util_ext_sync_gen_if.sv
// Control/status bundle for the external sync pulse generator.
// The master side drives the configuration and trigger/abort; the slave side is the generator.
interface util_ext_sync_gen_if #(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 8
);
    logic                    cfg_continuous;
    logic [PERIOD_WIDTH-1:0] cfg_period;
    logic [PERIOD_WIDTH-1:0] cfg_high;
    logic [COUNT_WIDTH-1:0]  cfg_count;
    logic                    trigger;
    logic                    abort;
    logic                    sync_out;
    logic                    busy;
    logic                    done;
    logic [COUNT_WIDTH-1:0]  pulse_cnt;

    modport master (
        output cfg_continuous, cfg_period, cfg_high, cfg_count, trigger, abort,
        input  sync_out, busy, done, pulse_cnt
    );

    modport slave (
        input  cfg_continuous, cfg_period, cfg_high, cfg_count, trigger, abort,
        output sync_out, busy, done, pulse_cnt
    );
endinterface

// File: rtl/util_ext_sync_gen.sv
// External sync (SYSREF-style) pulse train generator: one-shot burst of N pulses or
// continuous train, with programmable period and high time. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for trigger; sync_out low
// HIGH  | sync_out high, phase timer counts the high time
// LOW   | sync_out low, phase timer counts the remainder of the period
module util_ext_sync_gen #(
    parameter bit ENABLED      = 1'b1,
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    util_ext_sync_gen_if.slave    bus
);

    generate
        if (ENABLED) begin : g_gen
            localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);
            localparam logic [PERIOD_WIDTH-1:0] P_TWO = PERIOD_WIDTH'(2);
            localparam logic [COUNT_WIDTH-1:0]  C_ONE = COUNT_WIDTH'(1);

            typedef enum logic [1:0] {
                IDLE = 2'd0,
                HIGH = 2'd1,
                LOW  = 2'd2
            } state_t;

            state_t                  state, state_nxt;
            logic [PERIOD_WIDTH-1:0] period_q, period_nxt;
            logic [PERIOD_WIDTH-1:0] high_q, high_nxt;
            logic [PERIOD_WIDTH-1:0] tmr_q, tmr_nxt;
            logic [COUNT_WIDTH-1:0]  count_q, count_nxt;
            logic [COUNT_WIDTH-1:0]  pulse_cnt_q, pulse_cnt_nxt;
            logic                    cont_q, cont_nxt;
            logic                    sync_q, sync_nxt;
            logic                    busy_q, busy_nxt;
            logic                    done_q, done_nxt;

            logic [PERIOD_WIDTH-1:0] p_san;
            logic [PERIOD_WIDTH-1:0] h_san;
            logic [COUNT_WIDTH-1:0]  n_san;
            logic                    accept;

            // Sanitised capture values: at least one high and one low cycle per period.
            always_comb begin
                p_san = (bus.cfg_period < P_TWO) ? P_TWO : bus.cfg_period;
                if (bus.cfg_high == '0)
                    h_san = P_ONE;
                else if (bus.cfg_high >= p_san)
                    h_san = p_san - P_ONE;
                else
                    h_san = bus.cfg_high;
                n_san = (bus.cfg_count == '0) ? C_ONE : bus.cfg_count;
            end

            // Blocking on done_q keeps a minimum two-cycle gap between back-to-back bursts.
            assign accept = bus.trigger && !bus.abort && !done_q;

            always_comb begin
                state_nxt     = state;
                period_nxt    = period_q;
                high_nxt      = high_q;
                tmr_nxt       = tmr_q;
                count_nxt     = count_q;
                pulse_cnt_nxt = pulse_cnt_q;
                cont_nxt      = cont_q;
                sync_nxt      = sync_q;
                busy_nxt      = busy_q;
                done_nxt      = 1'b0;

                case (state)
                    IDLE: begin
                        sync_nxt = 1'b0;
                        busy_nxt = 1'b0;
                        if (accept) begin
                            state_nxt     = HIGH;
                            period_nxt    = p_san;
                            high_nxt      = h_san;
                            count_nxt     = n_san;
                            cont_nxt      = bus.cfg_continuous;
                            tmr_nxt       = h_san;
                            pulse_cnt_nxt = C_ONE;
                            sync_nxt      = 1'b1;
                            busy_nxt      = 1'b1;
                        end
                    end
                    HIGH: begin
                        if (bus.abort) begin
                            state_nxt = IDLE;
                            sync_nxt  = 1'b0;
                            busy_nxt  = 1'b0;
                        end else if (tmr_q == P_ONE) begin
                            sync_nxt = 1'b0;
                            if (!cont_q && pulse_cnt_q == count_q) begin
                                state_nxt = IDLE;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = LOW;
                                tmr_nxt   = period_q - high_q;
                            end
                        end else begin
                            tmr_nxt = tmr_q - P_ONE;
                        end
                    end
                    LOW: begin
                        if (bus.abort) begin
                            state_nxt = IDLE;
                            sync_nxt  = 1'b0;
                            busy_nxt  = 1'b0;
                        end else if (tmr_q == P_ONE) begin
                            state_nxt     = HIGH;
                            tmr_nxt       = high_q;
                            sync_nxt      = 1'b1;
                            pulse_cnt_nxt = pulse_cnt_q + C_ONE;
                        end else begin
                            tmr_nxt = tmr_q - P_ONE;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        sync_nxt  = 1'b0;
                        busy_nxt  = 1'b0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state       <= IDLE;
                    period_q    <= P_TWO;
                    high_q      <= P_ONE;
                    tmr_q       <= P_ONE;
                    count_q     <= C_ONE;
                    pulse_cnt_q <= '0;
                    cont_q      <= 1'b0;
                    sync_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end else begin
                    state       <= state_nxt;
                    period_q    <= period_nxt;
                    high_q      <= high_nxt;
                    tmr_q       <= tmr_nxt;
                    count_q     <= count_nxt;
                    pulse_cnt_q <= pulse_cnt_nxt;
                    cont_q      <= cont_nxt;
                    sync_q      <= sync_nxt;
                    busy_q      <= busy_nxt;
                    done_q      <= done_nxt;
                end
            end

            assign bus.sync_out  = sync_q;
            assign bus.busy      = busy_q;
            assign bus.done      = done_q;
            assign bus.pulse_cnt = pulse_cnt_q;
        end else begin : g_off
            assign bus.sync_out  = 1'b0;
            assign bus.busy      = 1'b0;
            assign bus.done      = 1'b0;
            assign bus.pulse_cnt = '0;
        end
    endgenerate

endmodule
